crc_ahb_mc_host_if: RTL
=======================

# crc_ahb_mc_host_if

Parametrised, multi-channel AHB-Lite slave front end for the CRC accelerator. It decodes one register bank per CRC channel and generates per-channel write enables, configuration and wait states from per-channel back-pressure. Unlike the single-channel interface, it accepts SEQ bursts, supports a read-only status register, and returns a two-cycle AHB ERROR for illegal accesses. It sits between the AHB interconnect and NUM_CH instances of the CRC datapath (buffer, CRC unit).

## Interface
- NUM_CH, 2: number of CRC channels (1..8); channel index = HADDR[7:5]
- HCLK  in  1  bus clock; all logic rising-edge
- HRESET  in  1  reset; one clock, synchronous and active-high
- HSEL, HWRITE, HREADY  in  1 each  AHB select, direction, bus-ready
- HADDR  in  32  address; [7:5] channel, [4:2] register
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HSIZE  in  3  transfer size
- HWDATA  in  32  write data (data phase, not pipelined)
- HRDATA  out  32  read data
- HREADYOUT, HRESP  out  1 each  ready and response (OKAY=0, ERROR=1)
- bus_wr  out  32  = HWDATA; bus_size  out  2  = registered HSIZE[1:0]
- buffer_write_en, crc_init_en, crc_idr_en, crc_poly_en, reset_chain  out  NUM_CH each  one-hot per-channel strobes
- crc_poly_size, rev_in_type  out  2*NUM_CH each; rev_out_type  out  NUM_CH
- crc_out, crc_init_out, crc_poly_out  in  32*NUM_CH; crc_idr_out  in  8*NUM_CH
- buffer_full, reset_pending, read_wait  in  NUM_CH each  per-channel stall sources

## Operation
- Register map (offset = HADDR[4:2]): 0 DR (rw), 1 IDR (rw), 2 CR (rw), 3 SR (ro), 4 INIT (rw), 5 POL (rw); 6, 7 unmapped.
- Address phase is sampled when HREADY && HREADYOUT. A transfer is valid when HSEL and HTRANS is NONSEQ or SEQ. IDLE and BUSY are no-ops and get a zero-wait OKAY.
- Illegal access, flagged at sampling: channel >= NUM_CH, offset 6/7, HSIZE > 3'b010, or a write to SR. An illegal transfer produces no strobes and takes the error path.
- Response FSM:
  - OK: HRESP=0; HREADYOUT per stall rule; an illegal data phase goes to ERR1.
  - ERR1: HREADYOUT=0, HRESP=1; always goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1; the bus is sampled here; goes to OK.
- Stall (OK state, channel c of the valid data phase):
  - DR write while buffer_full[c]
  - DR read while read_wait[c]
  - INIT write while reset_pending[c]
  - HREADYOUT=0 while any of these holds.
- Strobes are asserted only in the completing cycle (HREADYOUT=1), so each accepted write pulses exactly one cycle on bit c only.
- CR write: cr[c] <= HWDATA[7:3]. reset_chain[c] = CR write completing && HWDATA[0].
- Config fields: crc_poly_size[2c+:2]=cr[1:0]; rev_in_type[2c+:2]=cr[3:2]; rev_out_type[c]=cr[4].
- HRDATA during a valid read data phase of channel c:
  - DR=crc_out, INIT=crc_init_out, POL=crc_poly_out
  - IDR={24'h0,idr}, CR={24'h0,cr,3'b0}, SR={29'h0,read_wait,reset_pending,buffer_full}
  - 32'h0 otherwise.

## Timing
- Reset values: FSM=OK; pipeline valid=0; all cr=0; HREADYOUT=1, HRESP=0, HRDATA=0; all strobes=0; config outputs=0; bus_size=0.
- Reset mid-transfer (stall or ERR1/ERR2) aborts it. The next cycle is idle with HREADYOUT=1, and no strobe is issued.
- Latency: strobes and HRDATA are valid in the cycle after the address phase, extended by stall cycles. Config outputs change the cycle after the CR write completes.
- Back-to-back SEQ: one transfer per cycle when unstalled. The address of transfer n+1 is held in place while transfer n stalls.
- An error adds exactly 1 wait cycle (ERR1), then a completing ERR2 cycle. A transfer sampled in ERR2 proceeds normally, including another error.
- A stall source deasserting makes HREADYOUT=1 and the strobe fire combinationally in the same cycle.

## Test plan
- Reset, then NONSEQ write 32'h0000_00A9 to ch1 CR (0x28), then read 0x28 -> reset_chain=2'b10 for one cycle; rev_out_type[1]=1, rev_in_type[3:2]=2'b01, crc_poly_size[3:2]=2'b01; read returns 32'h0000_00A8.
- 4-beat SEQ write burst to ch0 DR with a BUSY after beat 2, and buffer_full[0] high for 3 cycles on beat 3 -> exactly 4 buffer_write_en[0] pulses; 3 HREADYOUT=0 cycles; BUSY gets a zero-wait OKAY.
- Write to SR (0x0C), to offset 6 (0x18), to ch2 with NUM_CH=2 (0x40), and HSIZE=3 -> each returns HRESP=1 for 2 cycles with HREADYOUT 0 then 1; no strobes.
- INIT write to ch0 with reset_pending[0]=1 for 2 cycles -> HREADYOUT low for 2 cycles; single crc_init_en=2'b01 pulse on release.
- Assert HRESET during a DR-write stall -> next cycle HREADYOUT=1, no buffer_write_en; CR reads back 0.
- Read SR of ch1 with read_wait[1]=1 and buffer_full[1]=1 -> HRDATA=32'h0000_0005, zero wait.

Source files
------------

// File: rtl/crc_ahb_mc_host_if_if.sv
// AHB-Lite bus bundle for the multi-channel CRC host interface.
// Signals:
//   HSEL, HWRITE, HREADY, HADDR, HTRANS, HSIZE, HWDATA : master -> slave
//   HRDATA, HREADYOUT, HRESP                           : slave  -> master
interface crc_ahb_mc_host_if_if;
  logic        HSEL;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HWRITE, HREADY, HADDR, HTRANS, HSIZE, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HWRITE, HREADY, HADDR, HTRANS, HSIZE, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/crc_ahb_mc_host_if.sv
// Multi-channel AHB-Lite slave front end for the CRC accelerator.
// Decodes one register bank per channel (channel = HADDR[7:5], register =
// HADDR[4:2]), produces one-hot per-channel write strobes and configuration,
// inserts wait states from per-channel back-pressure and answers illegal
// accesses with a two-cycle ERROR response.
// Ports:
//   HCLK, HRESET        clock, synchronous active-high reset
//   ahb                 AHB-Lite slave bundle
//   bus_wr, bus_size    write data and registered transfer size to datapath
//   *_en, reset_chain   per-channel one-cycle strobes
//   crc_poly_size, rev_in_type, rev_out_type   per-channel CR fields
//   crc_out, crc_init_out, crc_poly_out, crc_idr_out   per-channel read data
//   buffer_full, reset_pending, read_wait      per-channel stall sources
module crc_ahb_mc_host_if #(
  parameter int NUM_CH = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  crc_ahb_mc_host_if_if.slave   ahb,
  output logic [31:0]           bus_wr,
  output logic [1:0]            bus_size,
  output logic [NUM_CH-1:0]     buffer_write_en,
  output logic [NUM_CH-1:0]     crc_init_en,
  output logic [NUM_CH-1:0]     crc_idr_en,
  output logic [NUM_CH-1:0]     crc_poly_en,
  output logic [NUM_CH-1:0]     reset_chain,
  output logic [2*NUM_CH-1:0]   crc_poly_size,
  output logic [2*NUM_CH-1:0]   rev_in_type,
  output logic [NUM_CH-1:0]     rev_out_type,
  input  logic [32*NUM_CH-1:0]  crc_out,
  input  logic [32*NUM_CH-1:0]  crc_init_out,
  input  logic [32*NUM_CH-1:0]  crc_poly_out,
  input  logic [8*NUM_CH-1:0]   crc_idr_out,
  input  logic [NUM_CH-1:0]     buffer_full,
  input  logic [NUM_CH-1:0]     reset_pending,
  input  logic [NUM_CH-1:0]     read_wait
);

  localparam logic [2:0] REG_DR   = 3'd0;
  localparam logic [2:0] REG_IDR  = 3'd1;
  localparam logic [2:0] REG_CR   = 3'd2;
  localparam logic [2:0] REG_SR   = 3'd3;
  localparam logic [2:0] REG_INIT = 3'd4;
  localparam logic [2:0] REG_POL  = 3'd5;

  typedef enum logic [1:0] {ST_OK, ST_ERR1, ST_ERR2} state_t;

  state_t      state;
  logic        vld_p0;
  logic        wr_p0;
  logic [2:0]  ch_p0;
  logic [2:0]  reg_p0;
  logic [4:0]  cr [NUM_CH];

  logic [2:0]        addr_ch;
  logic [2:0]        addr_reg;
  logic              xfer;
  logic              illegal;
  logic              sample;
  logic              stall;
  logic              hready_out;
  logic              wr_done;
  logic [NUM_CH-1:0] ch_hit;
  logic [31:0]       rdata;
  logic              unused_bits;

  assign unused_bits = ^{ahb.HADDR[31:8], ahb.HADDR[1:0], ahb.HTRANS[0]};

  // Address phase decode
  assign addr_ch  = ahb.HADDR[7:5];
  assign addr_reg = ahb.HADDR[4:2];
  assign xfer     = ahb.HSEL && ahb.HTRANS[1];
  assign illegal  = (int'(addr_ch) >= NUM_CH) || (addr_reg > REG_POL) ||
                    (ahb.HSIZE > 3'b010) || (ahb.HWRITE && addr_reg == REG_SR);
  assign sample   = ahb.HREADY && hready_out;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= ST_OK;
      vld_p0   <= 1'b0;
      bus_size <= 2'b00;
    end else begin
      case (state)
        ST_ERR1: state <= ST_ERR2;
        // OK and ERR2 both accept a new address; an illegal one enters ERR1
        // so its data phase opens with the wait cycle of the error response.
        default: state <= (sample && xfer && illegal) ? ST_ERR1 : ST_OK;
      endcase
      // A completing data phase without a new sample leaves the pipe empty.
      if (hready_out) vld_p0 <= sample && xfer && !illegal;
      if (sample && xfer) bus_size <= ahb.HSIZE[1:0];
    end
  end

  always_ff @(posedge HCLK) begin
    if (sample) begin
      wr_p0  <= ahb.HWRITE;
      ch_p0  <= addr_ch;
      reg_p0 <= addr_reg;
    end
  end

  // Data phase: channel select, stall and response
  always_comb begin
    ch_hit = '0;
    for (int c = 0; c < NUM_CH; c++) ch_hit[c] = (ch_p0 == 3'(c));
  end

  assign stall = vld_p0 && |(ch_hit & (
                   ({NUM_CH{ wr_p0 && reg_p0 == REG_DR}}   & buffer_full) |
                   ({NUM_CH{!wr_p0 && reg_p0 == REG_DR}}   & read_wait)   |
                   ({NUM_CH{ wr_p0 && reg_p0 == REG_INIT}} & reset_pending)));

  always_comb begin
    case (state)
      ST_ERR1: hready_out = 1'b0;
      ST_ERR2: hready_out = 1'b1;
      default: hready_out = !stall;
    endcase
  end

  assign ahb.HREADYOUT = hready_out;
  assign ahb.HRESP     = (state != ST_OK);

  // Strobes fire only in the completing cycle; a reset cycle cancels them.
  assign wr_done = vld_p0 && wr_p0 && hready_out && !HRESET;

  assign buffer_write_en = ch_hit & {NUM_CH{wr_done && reg_p0 == REG_DR}};
  assign crc_idr_en      = ch_hit & {NUM_CH{wr_done && reg_p0 == REG_IDR}};
  assign crc_init_en     = ch_hit & {NUM_CH{wr_done && reg_p0 == REG_INIT}};
  assign crc_poly_en     = ch_hit & {NUM_CH{wr_done && reg_p0 == REG_POL}};
  assign reset_chain     = ch_hit & {NUM_CH{wr_done && reg_p0 == REG_CR && ahb.HWDATA[0]}};
  assign bus_wr          = ahb.HWDATA;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int c = 0; c < NUM_CH; c++) cr[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        if (wr_done && reg_p0 == REG_CR && ch_hit[c]) cr[c] <= ahb.HWDATA[7:3];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cfg
    assign crc_poly_size[2*g +: 2] = cr[g][1:0];
    assign rev_in_type[2*g +: 2]   = cr[g][3:2];
    assign rev_out_type[g]         = cr[g][4];
  end

  always_comb begin
    rdata = '0;
    if (vld_p0 && !wr_p0) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_hit[c]) begin
          case (reg_p0)
            REG_DR:   rdata = crc_out[32*c +: 32];
            REG_IDR:  rdata = {24'h0, crc_idr_out[8*c +: 8]};
            REG_CR:   rdata = {24'h0, cr[c], 3'b000};
            REG_SR:   rdata = {29'h0, read_wait[c], reset_pending[c], buffer_full[c]};
            REG_INIT: rdata = crc_init_out[32*c +: 32];
            REG_POL:  rdata = crc_poly_out[32*c +: 32];
            default:  rdata = '0;
          endcase
        end
      end
    end
  end

  assign ahb.HRDATA = rdata;

endmodule
